instr_encoder: RTL and testbench

Packs MIPS instruction fields (opcode, rs, rt, rd, shift, func, imm16, instr_index) into 32-bit instruction words and streams them, with sequential word addresses, into instruction memory. It is the inverse of the field decoder used in the decode stage. It sits between the testbench/boot program source and the IM write port, and preloads programs before the pipeline is released from reset.

---
 rtl/mips_enc_pkg.sv | 23 ++
 rtl/instr_encoder_pack.sv | 43 ++++
 rtl/instr_encoder.sv | 127 ++++++++++++
 tb/tb_instr_encoder.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_enc_pkg.sv
// Shared MIPS encoding constants: format codes, field bit positions and encoder states.
// The decode stage imports the same field positions.
package mips_enc_pkg;

    localparam logic [1:0] FMT_R   = 2'b00;
    localparam logic [1:0] FMT_I   = 2'b01;
    localparam logic [1:0] FMT_J   = 2'b10;
    localparam logic [1:0] FMT_RAW = 2'b11;

    localparam int unsigned OP_HI = 31;
    localparam int unsigned RS_HI = 25;
    localparam int unsigned RT_HI = 20;
    localparam int unsigned RD_HI = 15;
    localparam int unsigned SH_HI = 10;
    localparam int unsigned FN_HI = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } enc_state_e;

endpackage

// File: rtl/instr_encoder_pack.sv
// instr_pack: purely combinational packing of a MIPS field bundle into a 32-bit word.
module instr_pack
    import mips_enc_pkg::*;
(
    input  logic [1:0]  fmt_i,
    input  logic [5:0]  opcode_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shift_i,
    input  logic [5:0]  func_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] instr_index_i,
    input  logic [31:0] raw_i,
    output logic [31:0] word_o
);

    always_comb begin
        word_o = '0;
        case (fmt_i)
            FMT_R: begin
                word_o[OP_HI -: 6] = opcode_i;
                word_o[RS_HI -: 5] = rs_i;
                word_o[RT_HI -: 5] = rt_i;
                word_o[RD_HI -: 5] = rd_i;
                word_o[SH_HI -: 5] = shift_i;
                word_o[FN_HI -: 6] = func_i;
            end
            FMT_I: begin
                word_o[OP_HI -: 6] = opcode_i;
                word_o[RS_HI -: 5] = rs_i;
                word_o[RT_HI -: 5] = rt_i;
                word_o[RD_HI:0]    = imm16_i;
            end
            FMT_J: begin
                word_o[OP_HI -: 6] = opcode_i;
                word_o[RS_HI:0]    = instr_index_i;
            end
            default: word_o = raw_i;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs field bundles into instruction words and streams them with
// sequential byte addresses to the instruction-memory write port during a load session.
module instr_encoder
    import mips_enc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned CNT_W     = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_fmt,
    input  logic [5:0]       in_opcode,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_shift,
    input  logic [5:0]       in_func,
    input  logic [15:0]      in_imm16,
    input  logic [25:0]      in_instr_index,
    input  logic [31:0]      in_raw,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_addr,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             full
);

    enc_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_data_q, out_data_d;
    logic [31:0]      out_addr_q, out_addr_d;
    logic [31:0]      packed_word;
    logic             accept;

    instr_pack u_pack (
        .fmt_i         (in_fmt),
        .opcode_i      (in_opcode),
        .rs_i          (in_rs),
        .rt_i          (in_rt),
        .rd_i          (in_rd),
        .shift_i       (in_shift),
        .func_i        (in_func),
        .imm16_i       (in_imm16),
        .instr_index_i (in_instr_index),
        .raw_i         (in_raw),
        .word_o        (packed_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        // stop wins over a simultaneous bundle; in_ready is already 0 outside LOAD
        accept      = in_valid && in_ready && !stop;

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = packed_word;
            out_addr_d  = BASE_ADDR + (32'(count_q) << 2);
            count_d     = count_q + 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start && !out_valid_q) begin
                    state_d = LOAD;
                    count_d = '0;
                end
            end
            LOAD: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (accept && (count_d == CNT_W'(DEPTH))) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start && !out_valid_q) begin
                    state_d = LOAD;
                    count_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == LOAD) && (!out_valid_q || out_ready);
        busy      = (state_q != IDLE) || out_valid_q;
        full      = (state_q == FULL);
        out_valid = out_valid_q;
        out_data  = out_data_q;
        out_addr  = out_addr_q;
        count     = count_q;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: encoding table, multi-cycle corner sequences,
// then randomized traffic against a session-level reference model.
module tb_instr_encoder;

    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam int          DEPTH = 4;
    localparam int          CW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, stop, in_valid, in_ready;
    logic [1:0]    in_fmt;
    logic [5:0]    in_opcode, in_func;
    logic [4:0]    in_rs, in_rt, in_rd, in_shift;
    logic [15:0]   in_imm16;
    logic [25:0]   in_instr_index;
    logic [31:0]   in_raw;
    logic          out_valid, out_ready;
    logic [31:0]   out_addr, out_data;
    logic [CW-1:0] count;
    logic          busy, full;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shift(in_shift), .in_func(in_func), .in_imm16(in_imm16),
        .in_instr_index(in_instr_index), .in_raw(in_raw),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .count(count), .busy(busy), .full(full)
    );

    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [31:0] raw;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_vec(input vec_t v);
        in_fmt = v.fmt; in_opcode = v.op; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd;
        in_shift = v.sh; in_func = v.fn; in_imm16 = v.imm; in_instr_index = v.idx;
        in_raw = v.raw;
    endtask

    task automatic drive_raw(input logic [31:0] w);
        in_fmt = 2'b11; in_raw = w;
        in_opcode = 6'h3F; in_rs = 5'h1F; in_rt = 5'h1F; in_rd = 5'h1F;
        in_shift = 5'h1F; in_func = 6'h3F; in_imm16 = 16'hFFFF; in_instr_index = '1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    // Reference encoding from field weights (plain arithmetic).
    function automatic logic [31:0] ref_enc(input int fmt, input longint op, input longint rs,
                                            input longint rt, input longint rd, input longint sh,
                                            input longint fn, input longint imm, input longint idx,
                                            input longint raw);
        longint v;
        case (fmt)
            0: v = op * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + sh * 64'd64 + fn;
            1: v = op * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imm;
            2: v = op * 64'd67108864 + idx;
            default: v = raw;
        endcase
        return v[31:0];
    endfunction

    // Session-level model state
    bit          m_open, m_full, m_pend;
    int          m_cnt;
    logic [31:0] m_data, m_addr;

    initial begin
        vecs[0] = '{2'b00, 6'h00, 5'd1,  5'd2,  5'd3,  5'd0,  6'h21, 16'hFFFF, 26'h3FFFFFF, 32'hFFFFFFFF, 32'h00221821};
        vecs[1] = '{2'b01, 6'h0D, 5'd0,  5'd1,  5'h1F, 5'h1F, 6'h3F, 16'h1234, 26'h3FFFFFF, 32'hFFFFFFFF, 32'h34011234};
        vecs[2] = '{2'b10, 6'h02, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 6'h3F, 16'hFFFF, 26'h0000C00, 32'hFFFFFFFF, 32'h08000C00};
        vecs[3] = '{2'b11, 6'h3F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[4] = '{2'b00, 6'h3F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 6'h3F, 16'h0000, 26'h0000000, 32'h00000000, 32'hFFFFFFFF};
        vecs[5] = '{2'b00, 6'h00, 5'd0,  5'd0,  5'd0,  5'h1F, 6'h00, 16'hFFFF, 26'h3FFFFFF, 32'hFFFFFFFF, 32'h000007C0};
        vecs[6] = '{2'b01, 6'h23, 5'd29, 5'd8,  5'h1F, 5'h1F, 6'h3F, 16'hFFFC, 26'h3FFFFFF, 32'hFFFFFFFF, 32'h8FA8FFFC};
        vecs[7] = '{2'b10, 6'h03, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 32'h00000000, 32'h0FFFFFFF};
        vecs[8] = '{2'b00, 6'h00, 5'h10, 5'd0,  5'd0,  5'd0,  6'h00, 16'hFFFF, 26'h3FFFFFF, 32'hFFFFFFFF, 32'h02000000};

        reset = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive_vec(vecs[0]);
        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_addr",  out_addr, 0);
        chk("rst_out_data",  out_data, 0);
        chk("rst_count",     32'(count), 0);
        chk("rst_in_ready",  32'(in_ready), 0);
        chk("rst_busy",      32'(busy), 0);
        chk("rst_full",      32'(full), 0);
        reset = 1'b1;
        tick();

        // Encoding table: one word per short session
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            pulse_start();
            chk("tbl_in_ready", 32'(in_ready), 1);
            drive_vec(vecs[i]);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            chk($sformatf("tbl_data[%0d]", i), out_data, vecs[i].exp);
            chk($sformatf("tbl_addr[%0d]", i), out_addr, BASE);
            chk($sformatf("tbl_valid[%0d]", i), 32'(out_valid), 1);
            chk($sformatf("tbl_count[%0d]", i), 32'(count), 1);
            pulse_stop();
            chk($sformatf("tbl_busy_end[%0d]", i), 32'(busy), 0);
        end

        // I then J back to back
        pulse_start();
        drive_vec(vecs[1]); in_valid = 1'b1; tick();
        chk("ij_data0", out_data, 32'h34011234);
        chk("ij_addr0", out_addr, 32'h3000);
        drive_vec(vecs[2]); tick();
        in_valid = 1'b0;
        chk("ij_data1", out_data, 32'h08000C00);
        chk("ij_addr1", out_addr, 32'h3004);
        chk("ij_valid1", 32'(out_valid), 1);
        tick();
        chk("ij_drained", 32'(out_valid), 0);
        pulse_stop();

        // Backpressure
        pulse_start();
        out_ready = 1'b0;
        drive_raw(32'hA0A0_0001); in_valid = 1'b1; tick();
        drive_raw(32'hB0B0_0002);
        for (int c = 0; c < 3; c++) begin
            #1 chk("bp_in_ready", 32'(in_ready), 0);
            tick();
            chk("bp_data_hold", out_data, 32'hA0A0_0001);
            chk("bp_addr_hold", out_addr, 32'h3000);
            chk("bp_valid_hold", 32'(out_valid), 1);
            chk("bp_count_hold", 32'(count), 1);
        end
        out_ready = 1'b1;
        #1 chk("bp_in_ready_resume", 32'(in_ready), 1);
        tick();
        chk("bp_data_b", out_data, 32'hB0B0_0002);
        chk("bp_addr_b", out_addr, 32'h3004);
        drive_raw(32'hC0C0_0003); tick();
        in_valid = 1'b0;
        chk("bp_data_c", out_data, 32'hC0C0_0003);
        chk("bp_addr_c", out_addr, 32'h3008);
        chk("bp_count_c", 32'(count), 3);
        tick();
        chk("bp_drained", 32'(out_valid), 0);
        pulse_stop();

        // Fill to DEPTH, fifth bundle refused
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            drive_raw(32'h1000 + 32'(k)); in_valid = 1'b1;
            #1 chk($sformatf("full_in_ready[%0d]", k), 32'(in_ready), (k < 4) ? 1 : 0);
            tick();
            if (k < 4) begin
                chk($sformatf("full_data[%0d]", k), out_data, 32'h1000 + 32'(k));
                chk($sformatf("full_addr[%0d]", k), out_addr, BASE + 32'(4 * k));
                chk($sformatf("full_count[%0d]", k), 32'(count), 32'(k + 1));
                chk($sformatf("full_flag[%0d]", k), 32'(full), (k == 3) ? 1 : 0);
            end else begin
                chk("full_5th_not_accepted", 32'(out_valid), 0);
                chk("full_count_held", 32'(count), 4);
                chk("full_flag_held", 32'(full), 1);
            end
        end
        in_valid = 1'b0;
        pulse_start();
        chk("refill_count", 32'(count), 0);
        chk("refill_full", 32'(full), 0);
        drive_raw(32'hABCD); in_valid = 1'b1; tick();
        in_valid = 1'b0;
        chk("refill_addr", out_addr, 32'h3000);
        chk("refill_data", out_data, 32'hABCD);
        tick();
        pulse_stop();

        // stop beats a simultaneous bundle
        pulse_start();
        drive_raw(32'h5555); in_valid = 1'b1; stop = 1'b1;
        #1 chk("stop_in_ready", 32'(in_ready), 1);
        tick();
        stop = 1'b0; in_valid = 1'b0;
        chk("stop_no_accept", 32'(out_valid), 0);
        chk("stop_count", 32'(count), 0);
        chk("stop_idle_ready", 32'(in_ready), 0);
        chk("stop_busy", 32'(busy), 0);
        // stop with a word pending: it still drains
        pulse_start();
        out_ready = 1'b0;
        drive_raw(32'h6666); in_valid = 1'b1; tick();
        drive_raw(32'h7777); stop = 1'b1; tick();
        stop = 1'b0; in_valid = 1'b0;
        chk("stopp_valid", 32'(out_valid), 1);
        chk("stopp_data", out_data, 32'h6666);
        chk("stopp_busy", 32'(busy), 1);
        chk("stopp_in_ready", 32'(in_ready), 0);
        out_ready = 1'b1; tick();
        chk("stopp_drained", 32'(out_valid), 0);
        chk("stopp_busy_fall", 32'(busy), 0);

        // Asynchronous reset with a stalled word
        pulse_start();
        out_ready = 1'b0;
        drive_raw(32'h9999); in_valid = 1'b1; tick();
        in_valid = 1'b0;
        chk("ar_valid_before", 32'(out_valid), 1);
        #2 reset = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 0);
        chk("ar_count", 32'(count), 0);
        chk("ar_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        reset = 1'b1; out_ready = 1'b1;
        tick();
        chk("ar_in_ready_after", 32'(in_ready), 0);
        chk("ar_valid_after", 32'(out_valid), 0);

        // Randomized traffic against the session model
        m_open = 0; m_full = 0; m_pend = 0; m_cnt = 0; m_data = '0; m_addr = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            int f, op, rs, rt, rd, sh, fn, imm, idx;
            logic [31:0] raw, w;
            bit exp_ready, acc, old_pend, old_full;

            chk("rnd_valid", 32'(out_valid), 32'(m_pend));
            chk("rnd_count", 32'(count), 32'(m_cnt));
            chk("rnd_full",  32'(full), 32'(m_full));
            chk("rnd_busy",  32'(busy), 32'(m_open || m_pend));
            if (m_pend) begin
                chk("rnd_data", out_data, m_data);
                chk("rnd_addr", out_addr, m_addr);
            end

            f = int'($urandom_range(0, 3)); op = int'($urandom_range(0, 63));
            rs = int'($urandom_range(0, 31)); rt = int'($urandom_range(0, 31));
            rd = int'($urandom_range(0, 31)); sh = int'($urandom_range(0, 31));
            fn = int'($urandom_range(0, 63)); imm = int'($urandom_range(0, 65535));
            idx = int'($urandom_range(0, 67108863)); raw = $urandom;
            in_fmt = 2'(f); in_opcode = 6'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
            in_shift = 5'(sh); in_func = 6'(fn); in_imm16 = 16'(imm); in_instr_index = 26'(idx);
            in_raw = raw;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            start     = ($urandom_range(0, 7) == 0);
            stop      = ($urandom_range(0, 15) == 0);
            w = ref_enc(f, op, rs, rt, rd, sh, fn, imm, idx, longint'(raw));

            exp_ready = m_open && !m_full && (!m_pend || out_ready);
            #1 chk("rnd_in_ready", 32'(in_ready), 32'(exp_ready));

            acc = exp_ready && in_valid && !stop;
            old_pend = m_pend; old_full = m_full;
            if (acc) begin
                m_data = w; m_addr = BASE + 32'(4 * m_cnt);
                m_cnt++; m_pend = 1;
                if (m_cnt == DEPTH) m_full = 1;
            end else if (out_ready) begin
                m_pend = 0;
            end
            if (m_open) begin
                if (stop) begin
                    m_open = 0; m_full = 0;
                end else if (old_full && start && !old_pend) begin
                    m_full = 0; m_cnt = 0;
                end
            end else if (start && !old_pend) begin
                m_open = 1; m_cnt = 0;
            end
            tick();
        end
        start = 1'b0; stop = 1'b0; in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
